// File: rtl/pc_gen_if.sv
// -----------------------------------------------------------------------------
// pc_gen_if
// Groups the control and data lines between the fetch-PC generator and the
// pipeline around it: hazard unit, D-stage comparator/decoder and CP0.
//   master : pipeline side (drives redirect/stall/exception requests,
//            observes the fetch PC and the RAS status)
//   slave  : pc_gen itself
// Parameters:
//   WIDTH     - PC / address width
//   RAS_DEPTH - return-address stack entries (sets the ras_count width)
// -----------------------------------------------------------------------------
interface pc_gen_if #(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
);
    localparam int CW = $clog2(RAS_DEPTH) + 1;

    logic             stall;
    logic [WIDTH-1:0] pc_d;
    logic             br_taken;
    logic [15:0]      br_imm;
    logic             j_en;
    logic             j_link;
    logic [25:0]      j_index;
    logic             jr_en;
    logic             jr_is_ra;
    logic [WIDTH-1:0] jr_target;
    logic             exc_req;
    logic             eret;
    logic [WIDTH-1:0] epc;

    logic [WIDTH-1:0] pc_f;
    logic [WIDTH-1:0] pc_f_plus4;
    logic             pc_adel;
    logic             ras_mispredict;
    logic [CW-1:0]    ras_count;
    logic [15:0]      redirect_cnt;

    modport master (
        output stall, pc_d, br_taken, br_imm, j_en, j_link, j_index,
               jr_en, jr_is_ra, jr_target, exc_req, eret, epc,
        input  pc_f, pc_f_plus4, pc_adel, ras_mispredict, ras_count,
               redirect_cnt
    );

    modport slave (
        input  stall, pc_d, br_taken, br_imm, j_en, j_link, j_index,
               jr_en, jr_is_ra, jr_target, exc_req, eret, epc,
        output pc_f, pc_f_plus4, pc_adel, ras_mispredict, ras_count,
               redirect_cnt
    );
endinterface

// File: rtl/pc_gen.sv
// -----------------------------------------------------------------------------
// pc_gen
// Fetch-PC generator for the pipelined MIPS core. Holds the F-stage PC and
// applies stall, D-stage redirects (branch, j/jal, jr), exception entry and
// eret. A small circular return-address stack is pushed on jal and popped on
// jr $ra; it only flags mispredictions, the PC always follows jr_target.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high reset (overrides every other input)
//   bus   - pc_gen_if slave modport (pipeline inputs, PC/RAS outputs)
// -----------------------------------------------------------------------------
module pc_gen #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = 32'h0000_3000,
    parameter logic [WIDTH-1:0] EXC_VEC   = 32'h0000_4180,
    parameter logic [WIDTH-1:0] IM_BASE   = 32'h0000_3000,
    parameter logic [WIDTH-1:0] IM_SIZE   = 32'h0000_4000,
    parameter int               RAS_DEPTH = 4
) (
    input  logic    clk,
    input  logic    reset,
    pc_gen_if.slave bus
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [WIDTH-1:0] FOUR  = WIDTH'(4);
    localparam logic [WIDTH-1:0] EIGHT = WIDTH'(8);
    // One bit wider so a fetch window touching the top of memory cannot wrap.
    localparam logic [WIDTH:0]   IM_END = {1'b0, IM_BASE} + {1'b0, IM_SIZE};
    localparam logic [CW-1:0]    RAS_FULL = CW'(RAS_DEPTH);

    logic [WIDTH-1:0] pc_f_q, pc_f_d;
    logic [15:0]      redirect_cnt_q, redirect_cnt_d;
    logic             redirect_s;

    logic [WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [PW-1:0]    ptr_q, ptr_d, ptr_m1_s;
    logic [CW-1:0]    count_q, count_d;
    logic             mispredict_q, mispredict_d;
    logic             ras_upd_s, push_s, pop_s;

    logic [WIDTH-1:0] br_off_s;

    assign br_off_s = {{(WIDTH-18){bus.br_imm[15]}}, bus.br_imm, 2'b00};
    assign ptr_m1_s = ptr_q - PW'(1);

    // Next fetch PC by fixed priority; also flags edges that count as a redirect.
    always_comb begin
        pc_f_d     = pc_f_q + FOUR;
        redirect_s = 1'b0;
        if (bus.exc_req) begin
            pc_f_d     = EXC_VEC;
            redirect_s = 1'b1;
        end else if (bus.eret) begin
            pc_f_d     = bus.epc;
            redirect_s = 1'b1;
        end else if (bus.stall) begin
            pc_f_d     = pc_f_q;
        end else if (bus.br_taken) begin
            // Delay slot already fetched: target is relative to pc_d+4.
            pc_f_d     = bus.pc_d + FOUR + br_off_s;
            redirect_s = 1'b1;
        end else if (bus.jr_en) begin
            pc_f_d     = bus.jr_target;
            redirect_s = 1'b1;
        end else if (bus.j_en) begin
            pc_f_d     = {bus.pc_d[WIDTH-1:28], bus.j_index, 2'b00};
            redirect_s = 1'b1;
        end else begin
            pc_f_d     = pc_f_q + FOUR;
        end
    end

    // Saturating redirect counter.
    always_comb begin
        redirect_cnt_d = redirect_cnt_q;
        if (redirect_s && (redirect_cnt_q != 16'hFFFF)) begin
            redirect_cnt_d = redirect_cnt_q + 16'd1;
        end else begin
            redirect_cnt_d = redirect_cnt_q;
        end
    end

    // RAS control: jr beats j when decode raises both, so a jal is not pushed then.
    always_comb begin
        ras_upd_s    = !bus.stall && !bus.exc_req && !bus.eret;
        pop_s        = ras_upd_s && bus.jr_en && bus.jr_is_ra;
        push_s       = ras_upd_s && bus.j_en && bus.j_link && !bus.jr_en;
        ptr_d        = ptr_q;
        count_d      = count_q;
        mispredict_d = 1'b0;
        if (pop_s) begin
            if (count_q != CW'(0)) begin
                ptr_d        = ptr_m1_s;
                count_d      = count_q - CW'(1);
                mispredict_d = (ras_q[ptr_m1_s] != bus.jr_target);
            end else begin
                mispredict_d = 1'b1;
            end
        end else if (push_s) begin
            ptr_d = ptr_q + PW'(1);
            if (count_q != RAS_FULL) begin
                count_d = count_q + CW'(1);
            end else begin
                count_d = count_q;
            end
        end else begin
            ptr_d   = ptr_q;
            count_d = count_q;
        end
    end

    // PC, counter and RAS state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f_q         <= RESET_PC;
            redirect_cnt_q <= 16'd0;
            ptr_q          <= PW'(0);
            count_q        <= CW'(0);
            mispredict_q   <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= WIDTH'(0);
            end
        end else begin
            pc_f_q         <= pc_f_d;
            redirect_cnt_q <= redirect_cnt_d;
            ptr_q          <= ptr_d;
            count_q        <= count_d;
            mispredict_q   <= mispredict_d;
            if (push_s) begin
                ras_q[ptr_q] <= bus.pc_d + EIGHT;
            end
        end
    end

    assign bus.pc_f           = pc_f_q;
    assign bus.pc_f_plus4     = pc_f_q + FOUR;
    assign bus.pc_adel        = (pc_f_q[1:0] != 2'b00) ||
                                (pc_f_q < IM_BASE) ||
                                ({1'b0, pc_f_q} >= IM_END);
    assign bus.ras_mispredict = mispredict_q;
    assign bus.ras_count      = count_q;
    assign bus.redirect_cnt   = redirect_cnt_q;

endmodule
